// File: rtl/ahblite_dma_master.sv
`default_nettype none
// ============================================================================
// Module   : ahblite_dma_master
// Function : AHB-Lite master that copies a block of 32-bit words from src to
//            dst with one non-pipelined read/write pair per word.
// Revision : 1.0  initial release
// ============================================================================
module ahblite_dma_master #(
  parameter int         LEN_W     = 16,
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic             HCLK_i,
  input  logic             HRESET_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [31:0]      src_addr_i,
  input  logic [31:0]      dst_addr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [LEN_W-1:0] remaining_o,
  output logic [31:0]      HADDR_o,
  output logic [1:0]       HTRANS_o,
  output logic [2:0]       HSIZE_o,
  output logic [2:0]       HBURST_o,
  output logic [3:0]       HPROT_o,
  output logic             HMASTLOCK_o,
  output logic             HWRITE_o,
  output logic [31:0]      HWDATA_o,
  input  logic [31:0]      HRDATA_i,
  input  logic             HREADY_i,
  input  logic             HRESP_i
);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_RD_A = 3'd1;
  localparam logic [2:0] c_RD_D = 3'd2;
  localparam logic [2:0] c_WR_A = 3'd3;
  localparam logic [2:0] c_WR_D = 3'd4;
  localparam logic [2:0] c_FIN  = 3'd5;

  localparam logic [1:0]       c_HT_IDLE   = 2'b00;
  localparam logic [1:0]       c_HT_NONSEQ = 2'b10;
  localparam logic [LEN_W-1:0] c_ONE       = LEN_W'(1);
  localparam logic [31:0]      c_WORD_MASK = 32'hFFFF_FFFC;

  logic [2:0]       state_q, state_d;
  logic [31:0]      src_q, dst_q, data_q;
  logic [LEN_W-1:0] rem_q;
  logic             err_q;

  logic w_accept, w_rd_done, w_wr_done, w_err_set;

  assign w_accept  = (state_q == c_IDLE) && start_i;
  assign w_rd_done = (state_q == c_RD_D) && HREADY_i && !HRESP_i;
  assign w_wr_done = (state_q == c_WR_D) && HREADY_i && !HRESP_i;
  // Abort is honoured before an address is accepted or when a data phase ends.
  assign w_err_set = (((state_q == c_RD_A) || (state_q == c_WR_A)) && abort_i) ||
                     (((state_q == c_RD_D) || (state_q == c_WR_D)) && HREADY_i &&
                      (HRESP_i || abort_i));

  always_ff @(posedge HCLK_i or posedge HRESET_i) begin
    if (HRESET_i) begin
      state_q <= c_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE: if (start_i) state_d = (len_i == '0) ? c_FIN : c_RD_A;
      c_RD_A: begin
        if (abort_i)       state_d = c_FIN;
        else if (HREADY_i) state_d = c_RD_D;
      end
      c_RD_D: if (HREADY_i) state_d = (HRESP_i || abort_i) ? c_FIN : c_WR_A;
      c_WR_A: begin
        if (abort_i)       state_d = c_FIN;
        else if (HREADY_i) state_d = c_WR_D;
      end
      c_WR_D: begin
        if (HREADY_i)
          state_d = (HRESP_i || abort_i || (rem_q <= c_ONE)) ? c_FIN : c_RD_A;
      end
      c_FIN:   state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  always_ff @(posedge HCLK_i or posedge HRESET_i) begin
    if (HRESET_i) begin
      src_q  <= '0;
      dst_q  <= '0;
      data_q <= '0;
      rem_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (w_accept) begin
        src_q <= src_addr_i & c_WORD_MASK;
        dst_q <= dst_addr_i & c_WORD_MASK;
        rem_q <= len_i;
        err_q <= 1'b0;
      end
      if (w_rd_done) data_q <= HRDATA_i;
      if (w_wr_done) begin
        src_q <= src_q + 32'd4;
        dst_q <= dst_q + 32'd4;
        if (rem_q != '0) rem_q <= rem_q - c_ONE;
      end
      if (w_err_set) err_q <= 1'b1;
    end
  end

  always_comb begin
    HTRANS_o = c_HT_IDLE;
    HWRITE_o = 1'b0;
    HADDR_o  = src_q;
    busy_o   = 1'b1;
    done_o   = 1'b0;
    case (state_q)
      c_IDLE: busy_o = 1'b0;
      c_RD_A: if (!abort_i) HTRANS_o = c_HT_NONSEQ;
      c_WR_A: begin
        HADDR_o  = dst_q;
        HWRITE_o = 1'b1;
        if (!abort_i) HTRANS_o = c_HT_NONSEQ;
      end
      c_WR_D: HADDR_o = dst_q;
      c_FIN: begin
        busy_o = 1'b0;
        done_o = 1'b1;
      end
      default: busy_o = 1'b0;
    endcase
  end

  assign HWDATA_o    = data_q;
  assign err_o       = err_q;
  assign remaining_o = rem_q;
  assign HSIZE_o     = 3'b010;
  assign HBURST_o    = 3'b000;
  assign HPROT_o     = HPROT_VAL;
  assign HMASTLOCK_o = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_ahblite_dma_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahblite_dma_master
// Function : Randomized self-checking bench with a memory-backed AHB slave.
// Revision : 1.0  initial release
// ============================================================================
module tb_ahblite_dma_master;
  localparam int LEN_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             start = 1'b0, abort = 1'b0;
  logic [31:0]      src_addr = '0, dst_addr = '0;
  logic [LEN_W-1:0] len = '0;
  logic             busy, done, err;
  logic [LEN_W-1:0] remaining;
  logic [31:0]      haddr, hwdata;
  logic [31:0]      hrdata = '0;
  logic [1:0]       htrans;
  logic [2:0]       hsize, hburst;
  logic [3:0]       hprot;
  logic             hmastlock, hwrite;
  logic             hready = 1'b1, hresp = 1'b0;

  ahblite_dma_master #(.LEN_W(LEN_W), .HPROT_VAL(4'b0011)) dut (
    .HCLK_i(clk), .HRESET_i(rst), .start_i(start), .abort_i(abort),
    .src_addr_i(src_addr), .dst_addr_i(dst_addr), .len_i(len),
    .busy_o(busy), .done_o(done), .err_o(err), .remaining_o(remaining),
    .HADDR_o(haddr), .HTRANS_o(htrans), .HSIZE_o(hsize), .HBURST_o(hburst),
    .HPROT_o(hprot), .HMASTLOCK_o(hmastlock), .HWRITE_o(hwrite), .HWDATA_o(hwdata),
    .HRDATA_i(hrdata), .HREADY_i(hready), .HRESP_i(hresp)
  );

  int checks = 0;
  int errors = 0;

  // Bus-side memory and the reference model's private copy of it.
  logic [31:0] mem       [bit [31:0]];
  logic [31:0] model_mem [bit [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  function automatic logic [31:0] bus_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return init_word(a);
  endfunction
  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    return init_word(a);
  endfunction

  // Slave: decides HREADY/HRESP/HRDATA on the falling edge for the next rising edge.
  bit          s_pend = 0, s_pw = 0;
  logic [31:0] s_pa = '0, s_wd = '0;
  int          s_wcnt = 0, s_waits = 0, s_err_rd_idx = -1;
  int          s_rd_cnt = 0, s_wr_cnt = 0, s_viol = 0, nonseq_cnt = 0;
  logic [31:0] rd_log[$];
  logic [31:0] wr_log[$];

  always @(negedge clk) begin
    if (rst) begin
      s_pend = 0; hready = 1'b1; hresp = 1'b0; hrdata = '0;
    end else begin
      hresp = 1'b0; hready = 1'b1; hrdata = $urandom;
      if ({hsize, hburst, hprot, hmastlock} !== {3'b010, 3'b000, 4'b0011, 1'b0}) s_viol++;
      if (s_pend) begin
        if (htrans !== 2'b00 || haddr !== s_pa) s_viol++;
        if (s_pw && s_wcnt == s_waits) s_wd = hwdata;
        else if (s_pw && hwdata !== s_wd) s_viol++;
        if (s_wcnt > 0) begin
          hready = 1'b0; s_wcnt--;
        end else begin
          s_pend = 0;
          if (s_pw) begin
            mem[s_pa] = hwdata; s_wr_cnt++;
          end else begin
            hrdata = bus_rd(s_pa); hresp = (s_rd_cnt == s_err_rd_idx); s_rd_cnt++;
          end
        end
      end else if (htrans === 2'b10) begin
        nonseq_cnt++; s_pend = 1; s_pa = haddr; s_pw = hwrite; s_wcnt = s_waits;
        if (hwrite) wr_log.push_back(haddr);
        else        rd_log.push_back(haddr);
      end else if (htrans !== 2'b00) begin
        s_viol++;
      end
    end
  end

  // Reference model: word-by-word copy with error/abort cut-off and cycle cost.
  task automatic model_copy(input logic [31:0] s, d, input int n, err_idx, abort_after, waits,
                            output int exp_rem, output bit exp_err, output int exp_rd,
                            output int exp_wr, output int exp_lat);
    logic [31:0] sa, da;
    int ok;
    sa = s & 32'hFFFF_FFFC; da = d & 32'hFFFF_FFFC;
    ok = n; exp_err = 0; exp_rd = n; exp_lat = n * (4 + 2 * waits);
    if (err_idx >= 0 && err_idx < n) begin
      ok = err_idx; exp_rd = err_idx + 1; exp_err = 1;
      exp_lat = err_idx * (4 + 2 * waits) + 2 + waits;
    end else if (abort_after >= 0 && abort_after < n) begin
      ok = abort_after + 1; exp_rd = ok; exp_err = 1; exp_lat = -1;
    end
    for (int i = 0; i < ok; i++) model_mem[da + 32'(4 * i)] = model_rd(sa + 32'(4 * i));
    exp_wr = ok; exp_rem = n - ok;
  endtask

  function automatic int bus_bad(input logic [31:0] s, d, input int n, rd, wr);
    int b;
    logic [31:0] sa, da;
    b = s_viol; sa = s & 32'hFFFF_FFFC; da = d & 32'hFFFF_FFFC;
    if (rd_log.size() != rd) b++;
    if (wr_log.size() != wr) b++;
    foreach (rd_log[i]) if (rd_log[i] !== sa + 32'(4 * i)) b++;
    foreach (wr_log[i]) if (wr_log[i] !== da + 32'(4 * i)) b++;
    for (int i = 0; i <= n; i++) if (bus_rd(da + 32'(4 * i)) !== model_rd(da + 32'(4 * i))) b++;
    return b;
  endfunction

  task automatic do_copy(input logic [31:0] s, d, input int n, waits, err_idx, abort_after,
                         input bit restart, output int lat, output bit tmo,
                         output logic [1:0] first_ht, output logic [1:0] after_db);
    @(posedge clk); #1;
    s_waits = waits; s_err_rd_idx = err_idx; s_rd_cnt = 0; s_wr_cnt = 0; s_viol = 0;
    nonseq_cnt = 0; rd_log.delete(); wr_log.delete();
    src_addr = s; dst_addr = d; len = LEN_W'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; src_addr = $urandom; dst_addr = $urandom; len = LEN_W'($urandom);
    first_ht = htrans; lat = 0; tmo = 1; after_db = 2'bxx;
    for (int c = 0; c < 4000; c++) begin
      if (done) begin tmo = 0; break; end
      if (abort_after >= 0 && s_pend && s_pw && s_wr_cnt == abort_after) abort = 1'b1;
      if (restart) start = (lat == 2);
      @(posedge clk); #1; lat++;
    end
    abort = 1'b0; start = 1'b0;
    if (!tmo) begin
      @(posedge clk); #1;
      after_db = {done, busy};
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({htrans, haddr, hwrite, hwdata, busy, done, err, remaining} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0", {htrans, haddr, hwrite, hwdata, busy, done, err, remaining});
    end
    checks++;
    if ({hsize, hburst, hprot, hmastlock} !== {3'b010, 3'b000, 4'b0011, 1'b0}) begin
      errors++;
      $display("FAIL reset_constants got %h exp %h", {hsize, hburst, hprot, hmastlock}, {3'b010, 3'b000, 4'b0011, 1'b0});
    end
    rst = 1'b0;
  endtask

  task automatic test_copy_waits(input int waits, input string tag);
    int lat, rd, wr, el, rem, n, b;
    bit tmo, ee;
    logic [1:0] fh, adb;
    logic [31:0] s, d;
    for (int it = 0; it < 3; it++) begin
      if (it == 0) begin
        s = 32'h2000_0000; d = 32'h2000_0100; n = (waits == 0) ? 3 : 2;
      end else begin
        s = $urandom; d = $urandom; n = $urandom_range(1, 6);
      end
      model_copy(s, d, n, -1, -1, waits, rem, ee, rd, wr, el);
      do_copy(s, d, n, waits, -1, -1, 0, lat, tmo, fh, adb);
      checks++;
      if (tmo || lat != el) begin errors++; $display("FAIL %s_latency got %0d exp %0d (tmo %0d)", tag, lat, el, tmo); end
      checks++;
      if ({err, remaining} !== {ee, LEN_W'(rem)}) begin
        errors++; $display("FAIL %s_err_rem got %0d/%0d exp %0d/%0d", tag, err, remaining, ee, rem);
      end
      checks++;
      if (fh !== 2'b10) begin errors++; $display("FAIL %s_first_nonseq got %b exp 10", tag, fh); end
      checks++;
      if (adb !== 2'b00) begin errors++; $display("FAIL %s_done_pulse got %b exp 00", tag, adb); end
      b = bus_bad(s, d, n, rd, wr);
      checks++;
      if (b != 0) begin errors++; $display("FAIL %s_bus_mem got %0d bad exp 0", tag, b); end
    end
  endtask

  task automatic test_error();
    int lat, rd, wr, el, rem, b, w, ns;
    bit tmo, ee;
    logic [1:0] fh, adb;
    logic [31:0] s, d;
    s = $urandom; d = $urandom; w = $urandom_range(0, 1);
    model_copy(s, d, 4, 1, -1, w, rem, ee, rd, wr, el);
    do_copy(s, d, 4, w, 1, -1, 0, lat, tmo, fh, adb);
    checks++;
    if (tmo || lat != el) begin errors++; $display("FAIL err_latency got %0d exp %0d", lat, el); end
    ns = nonseq_cnt;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({err, remaining} !== {1'b1, LEN_W'(3)}) begin
      errors++; $display("FAIL err_sticky_rem got %0d/%0d exp 1/3", err, remaining);
    end
    checks++;
    if (nonseq_cnt != ns || ns != 3) begin errors++; $display("FAIL err_no_more_nonseq got %0d exp 3", nonseq_cnt); end
    b = bus_bad(s, d, 4, rd, wr);
    checks++;
    if (b != 0) begin errors++; $display("FAIL err_bus_mem got %0d bad exp 0", b); end
  endtask

  task automatic test_len0_busy_start();
    int lat, rd, wr, el, rem, b;
    bit tmo, ee;
    logic [1:0] fh, adb;
    logic [31:0] s, d;
    s = $urandom; d = $urandom;
    do_copy(s, d, 0, 0, -1, -1, 0, lat, tmo, fh, adb);
    checks++;
    if (tmo || lat != 0 || nonseq_cnt != 0) begin
      errors++; $display("FAIL len0_done got lat %0d nonseq %0d exp 0/0", lat, nonseq_cnt);
    end
    checks++;
    if ({err, remaining, adb} !== {1'b0, LEN_W'(0), 2'b00}) begin
      errors++; $display("FAIL len0_state got %0d/%0d/%b exp 0/0/00", err, remaining, adb);
    end
    s = $urandom; d = $urandom;
    model_copy(s, d, 3, -1, -1, 1, rem, ee, rd, wr, el);
    do_copy(s, d, 3, 1, -1, -1, 1, lat, tmo, fh, adb);
    checks++;
    if (tmo || lat != el) begin errors++; $display("FAIL busy_start_latency got %0d exp %0d", lat, el); end
    b = bus_bad(s, d, 3, rd, wr);
    checks++;
    if (b != 0 || adb !== 2'b00) begin errors++; $display("FAIL busy_start_bus got %0d bad exp 0", b); end
  endtask

  task automatic test_abort();
    int lat, rd, wr, el, rem, b, w;
    bit tmo, ee;
    logic [1:0] fh, adb;
    logic [31:0] s, d;
    s = $urandom; d = $urandom; w = $urandom_range(0, 2);
    model_copy(s, d, 5, -1, 1, w, rem, ee, rd, wr, el);
    do_copy(s, d, 5, w, -1, 1, 0, lat, tmo, fh, adb);
    checks++;
    if (tmo || {err, remaining} !== {1'b1, LEN_W'(3)}) begin
      errors++; $display("FAIL abort_err_rem got %0d/%0d exp 1/3 (tmo %0d)", err, remaining, tmo);
    end
    b = bus_bad(s, d, 5, rd, wr);
    checks++;
    if (b != 0) begin errors++; $display("FAIL abort_bus_mem got %0d bad exp 0", b); end
  endtask

  task automatic test_reset_wrap();
    int lat, rd, wr, el, rem, b;
    bit tmo, ee;
    logic [1:0] fh, adb;
    logic [31:0] d;
    @(posedge clk); #1;
    s_waits = 1; s_err_rd_idx = -1; s_wr_cnt = 0;
    src_addr = $urandom; dst_addr = $urandom; len = LEN_W'(4); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 100 && !(s_pend && s_pw); c++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (!(s_pend && s_pw)) begin errors++; $display("FAIL rst_reach_wr_data got 0 exp 1"); end
    rst = 1'b1;
    #1;
    checks++;
    if ({htrans, haddr, hwrite, hwdata, busy, done, err, remaining} !== '0) begin
      errors++;
      $display("FAIL rst_async_outputs got %h exp 0", {htrans, haddr, hwrite, hwdata, busy, done, err, remaining});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    d = ($urandom & 32'h0FFF_FFFC) | 32'h4000_0000;
    model_copy(32'hFFFF_FFFC, d, 2, -1, -1, 0, rem, ee, rd, wr, el);
    do_copy(32'hFFFF_FFFC, d, 2, 0, -1, -1, 0, lat, tmo, fh, adb);
    checks++;
    if (rd_log.size() != 2 || rd_log[1] !== 32'h0) begin
      errors++; $display("FAIL wrap_second_read got %h exp 00000000", (rd_log.size() > 1) ? rd_log[1] : 32'hx);
    end
    b = bus_bad(32'hFFFF_FFFC, d, 2, rd, wr);
    checks++;
    if (tmo || lat != el || err !== 1'b0 || b != 0) begin
      errors++; $display("FAIL wrap_copy got lat %0d err %0d bad %0d exp %0d/0/0", lat, err, b, el);
    end
  endtask

  task automatic test_back_to_back();
    int lat, rd, wr, el, rem, b, n, w, mode, ei, ab;
    bit tmo, ee;
    logic [1:0] fh, adb;
    logic [31:0] s, d;
    for (int it = 0; it < 8; it++) begin
      s = $urandom; d = $urandom; n = $urandom_range(2, 8); w = $urandom_range(0, 2);
      mode = $urandom_range(0, 2);
      ei = (mode == 1) ? $urandom_range(0, n - 1) : -1;
      ab = (mode == 2) ? $urandom_range(0, n - 2) : -1;
      model_copy(s, d, n, ei, ab, w, rem, ee, rd, wr, el);
      do_copy(s, d, n, w, ei, ab, 0, lat, tmo, fh, adb);
      checks++;
      if (tmo || (el >= 0 && lat != el)) begin
        errors++; $display("FAIL b2b_latency it %0d got %0d exp %0d (tmo %0d)", it, lat, el, tmo);
      end
      checks++;
      if ({err, remaining} !== {ee, LEN_W'(rem)}) begin
        errors++; $display("FAIL b2b_err_rem it %0d got %0d/%0d exp %0d/%0d", it, err, remaining, ee, rem);
      end
      b = bus_bad(s, d, n, rd, wr);
      checks++;
      if (b != 0) begin errors++; $display("FAIL b2b_bus_mem it %0d got %0d bad exp 0", it, b); end
    end
  endtask

  initial begin
    test_reset();
    test_copy_waits(0, "zero_wait");
    test_copy_waits(2, "wait_states");
    test_error();
    test_len0_busy_start();
    test_abort();
    test_reset_wrap();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
